// File: rtl/gemm_tiled_core.sv
// Tiled GEMM engine: walks RowPar x ColPar output tiles in row-major order,
// streams A/B words from synchronous SRAMs and writes one packed C tile per tile.
module gemm_tiled_core #(
    parameter int InDataWidth   = 8,
    parameter int OutDataWidth  = 32,
    parameter int RowPar        = 4,
    parameter int ColPar        = 16,
    parameter int AddrWidth     = 12,
    parameter int SizeAddrWidth = 32
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  start_i,
    input  logic [SizeAddrWidth-1:0]              M_size_i,
    input  logic [SizeAddrWidth-1:0]              K_size_i,
    input  logic [SizeAddrWidth-1:0]              N_size_i,
    output logic [AddrWidth-1:0]                  sram_a_addr_o,
    output logic [AddrWidth-1:0]                  sram_b_addr_o,
    input  logic [RowPar*InDataWidth-1:0]         sram_a_rdata_i,
    input  logic [ColPar*InDataWidth-1:0]         sram_b_rdata_i,
    output logic [AddrWidth-1:0]                  sram_c_addr_o,
    output logic [RowPar*ColPar*OutDataWidth-1:0] sram_c_wdata_o,
    output logic                                  sram_c_we_o,
    output logic                                  busy_o,
    output logic                                  done_o,
    output logic                                  err_o
);

    localparam int AccWidth = RowPar * ColPar * OutDataWidth;
    localparam logic [SizeAddrWidth-1:0] SzZero   = {SizeAddrWidth{1'b0}};
    localparam logic [SizeAddrWidth-1:0] SzOne    = {{(SizeAddrWidth-1){1'b0}}, 1'b1};
    localparam logic [SizeAddrWidth-1:0] RowStep  = SizeAddrWidth'(RowPar);
    localparam logic [SizeAddrWidth-1:0] ColStep  = SizeAddrWidth'(ColPar);
    localparam logic [AddrWidth-1:0]     AddrZero = {AddrWidth{1'b0}};
    localparam logic [AddrWidth-1:0]     AddrOne  = {{(AddrWidth-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t                   state_r, state_s;
    logic [SizeAddrWidth-1:0] m_r, k_size_r, n_r;
    logic [SizeAddrWidth-1:0] k_r, row_r, col_r;
    logic [AddrWidth-1:0]     a_base_r, b_base_r, tile_r;
    logic [AddrWidth-1:0]     k_step_s;
    logic                     valid_r, first_k_r;
    logic                     sizes_ok_s, last_k_s, last_col_s, last_row_s;
    logic [AccWidth-1:0]      acc_r, acc_s;

    // One signed multiply-accumulate lane; the product is exact and then sign-extended.
    function automatic logic [OutDataWidth-1:0] mac_step(
        input logic [OutDataWidth-1:0] base,
        input logic [InDataWidth-1:0]  a,
        input logic [InDataWidth-1:0]  b
    );
        logic signed [2*InDataWidth-1:0] prod;
        prod = $signed(a) * $signed(b);
        return base + OutDataWidth'(prod);
    endfunction

    // Size legality and end-of-loop conditions.
    always_comb begin
        sizes_ok_s = (M_size_i != SzZero) && (K_size_i != SzZero) && (N_size_i != SzZero) &&
                     ((M_size_i % RowStep) == SzZero) && ((N_size_i % ColStep) == SzZero);
        last_k_s   = (k_r == (k_size_r - SzOne));
        last_col_s = ((col_r + ColStep) == n_r);
        last_row_s = ((row_r + RowStep) == m_r);
        k_step_s   = k_size_r[AddrWidth-1:0];
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    state_s = sizes_ok_s ? ST_RUN : ST_DONE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_k_s) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DRAIN: state_s = ST_WRITE;
            ST_WRITE: begin
                if (last_col_s && last_row_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Accumulator update; first_k restarts a tile without a dead cycle.
    always_comb begin
        acc_s = acc_r;
        if (valid_r) begin
            for (int r = 0; r < RowPar; r++) begin
                for (int c = 0; c < ColPar; c++) begin
                    acc_s[(r*ColPar+c)*OutDataWidth +: OutDataWidth] = mac_step(
                        first_k_r ? {OutDataWidth{1'b0}}
                                  : acc_r[(r*ColPar+c)*OutDataWidth +: OutDataWidth],
                        sram_a_rdata_i[r*InDataWidth +: InDataWidth],
                        sram_b_rdata_i[c*InDataWidth +: InDataWidth]);
                end
            end
        end else begin
            acc_s = acc_r;
        end
    end

    // Control state, counters and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r        <= ST_IDLE;
            m_r            <= SzZero;
            k_size_r       <= SzZero;
            n_r            <= SzZero;
            k_r            <= SzZero;
            row_r          <= SzZero;
            col_r          <= SzZero;
            a_base_r       <= AddrZero;
            b_base_r       <= AddrZero;
            tile_r         <= AddrZero;
            valid_r        <= 1'b0;
            first_k_r      <= 1'b0;
            sram_a_addr_o  <= AddrZero;
            sram_b_addr_o  <= AddrZero;
            sram_c_addr_o  <= AddrZero;
            sram_c_wdata_o <= {AccWidth{1'b0}};
            sram_c_we_o    <= 1'b0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            err_o          <= 1'b0;
        end else begin
            state_r     <= state_s;
            busy_o      <= (state_s != ST_IDLE);
            done_o      <= (state_s == ST_DONE);
            err_o       <= (state_r == ST_IDLE) && (state_s == ST_DONE);
            sram_c_we_o <= (state_s == ST_WRITE);
            valid_r     <= (state_r == ST_RUN);
            first_k_r   <= (state_r == ST_RUN) && (k_r == SzZero);
            case (state_r)
                ST_IDLE: begin
                    if (start_i) begin
                        m_r           <= M_size_i;
                        k_size_r      <= K_size_i;
                        n_r           <= N_size_i;
                        k_r           <= SzZero;
                        row_r         <= SzZero;
                        col_r         <= SzZero;
                        a_base_r      <= AddrZero;
                        b_base_r      <= AddrZero;
                        tile_r        <= AddrZero;
                        sram_a_addr_o <= AddrZero;
                        sram_b_addr_o <= AddrZero;
                    end
                end
                ST_RUN: begin
                    if (!last_k_s) begin
                        k_r           <= k_r + SzOne;
                        sram_a_addr_o <= sram_a_addr_o + AddrOne;
                        sram_b_addr_o <= sram_b_addr_o + AddrOne;
                    end
                end
                ST_DRAIN: begin
                    // acc_s already holds the final product of the tile here.
                    sram_c_addr_o  <= tile_r;
                    sram_c_wdata_o <= acc_s;
                end
                ST_WRITE: begin
                    if (state_s == ST_RUN) begin
                        tile_r <= tile_r + AddrOne;
                        k_r    <= SzZero;
                        if (last_col_s) begin
                            col_r         <= SzZero;
                            row_r         <= row_r + RowStep;
                            b_base_r      <= AddrZero;
                            a_base_r      <= a_base_r + k_step_s;
                            sram_a_addr_o <= a_base_r + k_step_s;
                            sram_b_addr_o <= AddrZero;
                        end else begin
                            col_r         <= col_r + ColStep;
                            b_base_r      <= b_base_r + k_step_s;
                            sram_a_addr_o <= a_base_r;
                            sram_b_addr_o <= b_base_r + k_step_s;
                        end
                    end
                end
                ST_DONE: begin
                    k_r <= SzZero;
                end
                default: begin
                    k_r <= SzZero;
                end
            endcase
        end
    end

    // Accumulator storage.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_r <= {AccWidth{1'b0}};
        end else begin
            acc_r <= acc_s;
        end
    end

endmodule

// File: doc/gemm_tiled_core.md
Name: gemm_tiled_core

Overview:
- Parametrised successor to the fixed 4x16 single-tile GEMM accelerator.
- Computes C = A x B for any M, K, N that are multiples of RowPar and ColPar.
- Tiles the output into RowPar x ColPar blocks and walks them in row-major tile order.
- Drives single-port SRAMs for A, B and C (1-cycle synchronous read) and holds RowPar*ColPar signed MAC accumulators.

Parameters:
- InDataWidth, 8, width of one signed A/B element.
- OutDataWidth, 32, width of one signed accumulator/C element.
- RowPar, 4, tile rows; A word = RowPar*InDataWidth bits.
- ColPar, 16, tile columns; B word = ColPar*InDataWidth bits.
- AddrWidth, 12, SRAM address width (all three SRAMs).
- SizeAddrWidth, 32, width of the M/K/N size inputs.

Ports:
- clk_i in 1: clock.
- rst_i in 1: synchronous reset, active-high.
- start_i in 1: start request; sampled only in IDLE.
- M_size_i, K_size_i, N_size_i in SizeAddrWidth each: matrix sizes; latched on accepted start.
- sram_a_addr_o out AddrWidth: A read address.
- sram_b_addr_o out AddrWidth: B read address.
- sram_a_rdata_i in RowPar*InDataWidth: A read data.
- sram_b_rdata_i in ColPar*InDataWidth: B read data.
- sram_c_addr_o out AddrWidth: C write address.
- sram_c_wdata_o out RowPar*ColPar*OutDataWidth: one C tile.
- sram_c_we_o out 1: C write enable.
- busy_o out 1: high from the cycle after an accepted start through the done cycle.
- done_o out 1: one-cycle completion pulse.
- err_o out 1: high with done_o when the sizes were illegal.

Behaviour:
- Reset: all outputs 0, accumulators 0, FSM in IDLE. Reset mid-run aborts immediately, with no further C writes.
- Data layout, with MT = M/RowPar, NT = N/ColPar:
  - A word at mt*K+k: lane r (bits r*InDataWidth +: InDataWidth) = A[mt*RowPar+r][k].
  - B word at nt*K+k: lane c = B[k][nt*ColPar+c].
  - C word at mt*NT+nt: element (r,c) at bits (r*ColPar+c)*OutDataWidth.
  - Addresses are truncated to AddrWidth; the caller guarantees they fit.
- FSM states: IDLE, RUN, DRAIN, WRITE, DONE.
- IDLE:
  - start_i=1 latches the sizes and clears the tile counters (mt=nt=0).
  - Goes to RUN if sizes are legal; otherwise to DONE with err_o=1.
  - Illegal sizes: M=0, K=0, N=0, M mod RowPar != 0, or N mod ColPar != 0.
- RUN: runs K cycles, k=0..K-1.
  - Drives sram_a_addr_o = mt*K+k and sram_b_addr_o = nt*K+k.
  - Read data arrive one cycle later, flagged by an internal valid.
- Accumulate:
  - On valid, acc[r][c] <= (first_k ? 0 : acc[r][c]) + sext(a_r)*sext(b_c).
  - Arithmetic is signed, full-precision product sign-extended to OutDataWidth, sum wraps modulo 2^OutDataWidth.
  - first_k clears the accumulators for free at tile start, with no dead cycle.
- DRAIN: 1 cycle; the last product is accumulated.
- WRITE: 1 cycle.
  - sram_c_we_o=1, sram_c_addr_o=mt*NT+nt, sram_c_wdata_o = packed accumulators.
  - Then advances nt, wrapping to 0 and incrementing mt.
  - Next state is RUN, or DONE after the last tile.
- DONE: 1 cycle with done_o=1 (and err_o if error), busy_o still 1; then IDLE.
- Outside WRITE:
  - sram_c_we_o=0.
  - sram_c_wdata_o and sram_c_addr_o hold their last values.
  - A/B addresses hold their last values.
- Latency: with the start edge as cycle 0, done_o is high in cycle T*(K+2)+1, where T = MT*NT.
  - The WRITE for tile t (0-based) occurs in cycle (t+1)*(K+2).
  - Error case: done_o and err_o are high in cycle 1; no SRAM writes occur.
- start_i while busy is ignored; sizes changing mid-run have no effect.
- start_i in the same cycle as the DONE pulse is ignored; a new start is accepted the next cycle.

Test Plan:
- M=4, K=64, N=16, random signed data:
  - Exactly one write, at C addr 0, matching the golden result.
  - done_o in cycle 67; busy_o high in cycles 1..67.
- M=8, K=3, N=32 (4 tiles): writes at addrs 0,1,2,3 in cycles 5,10,15,20; done in cycle 21; every element matches golden.
- All A=-128, all B=-128, K=64 (OutDataWidth=32): every element = 1048576; then K=1 with A=-128, B=127 gives every element = -16256.
- Illegal sizes (M=5, then N=0, then K=0): done_o=err_o=1 in cycle 1; sram_c_we_o never asserted; busy_o=1 for one cycle only.
- rst_i asserted during RUN of tile 1 of a 2-tile job: next cycle all outputs 0 and FSM in IDLE; a new 4x2x16 start completes correctly, with no stale accumulation.
- start_i pulsed while busy and in the DONE cycle: both ignored; a back-to-back start the cycle after done is accepted and produces a correct second result.
